// File: rtl/apb_txn_monitor.sv
// Passive APB transfer monitor.
// Follows the setup/access handshake of one APB bus and records every completed
// transfer as {write, addr, data} in a first-word-fall-through FIFO that drains
// through a valid/ready port. Protocol violations raise a sticky error flag that
// keeps the code of the first violation. Records lost to a full FIFO are counted.
// The monitor only observes the bus and never drives it.

module apb_txn_monitor #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic                     rec_write,
    output logic [ADDR_W-1:0]        rec_addr,
    output logic [DATA_W-1:0]        rec_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     proto_err,
    output logic [1:0]               err_code,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] hold_addr;
    logic              hold_write;
    logic [DATA_W-1:0] hold_wdata;

    logic              bus_setup;
    logic              bus_match;
    logic              relatch;
    logic              complete;
    logic              err_hit;
    logic [1:0]        err_new;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count_next;
    logic [REC_W-1:0]  push_rec;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;

    // Decode the sampled bus against the current phase: completion, violation and re-latch.
    always_comb begin
        bus_setup = psel & ~penable;
        bus_match = psel & penable
                  & (paddr == hold_addr)
                  & (pwrite == hold_write)
                  & (~hold_write | (pwdata == hold_wdata));
        complete  = 1'b0;
        err_hit   = 1'b0;
        err_new   = 2'd0;
        relatch   = 1'b0;
        case (state)
            IDLE: begin
                relatch = bus_setup;
                if (psel & penable) begin
                    err_hit = 1'b1;
                    err_new = 2'd1;
                end
            end
            SETUP: begin
                if (bus_match) begin
                    complete = pready;
                end else begin
                    err_hit = 1'b1;
                    err_new = 2'd2;
                    relatch = bus_setup;
                end
            end
            ACCESS: begin
                if (bus_match) begin
                    complete = pready;
                end else begin
                    err_hit = 1'b1;
                    err_new = 2'd3;
                    relatch = bus_setup;
                end
            end
            default: begin
                complete = 1'b0;
            end
        endcase
    end

    // Protocol FSM: a failed check falls back to SETUP when a fresh setup is already on the bus.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_setup) state <= SETUP;
                end
                SETUP, ACCESS: begin
                    if (bus_match)      state <= pready ? IDLE : ACCESS;
                    else if (bus_setup) state <= SETUP;
                    else                state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture address, direction and write data whenever a new setup phase begins.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_wdata <= '0;
        end else if (relatch) begin
            hold_addr  <= paddr;
            hold_write <= pwrite;
            hold_wdata <= pwdata;
        end
    end

    // Sticky error: first code wins until cleared; a new error beats a simultaneous clear.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            proto_err <= 1'b0;
            err_code  <= 2'd0;
        end else if (err_hit && (!proto_err || err_clr)) begin
            proto_err <= 1'b1;
            err_code  <= err_new;
        end else if (err_clr) begin
            proto_err <= 1'b0;
            err_code  <= 2'd0;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        push_rec   = {hold_write, hold_addr, hold_write ? hold_wdata : prdata};
        pop        = rec_valid & rec_ready;
        full       = (fill_level == FULL_LVL);
        wr_en      = complete & (~full | pop);
        drop       = complete & full & ~pop;
        count_next = fill_level;
        if (wr_en && !pop)      count_next = fill_level + 1'b1;
        else if (!wr_en && pop) count_next = fill_level - 1'b1;
    end

    // Record storage, pointers, fill level and the registered valid flag.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            rec_valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fill_level <= count_next;
            rec_valid  <= (count_next != '0);
        end
    end

    // Count records lost to a full FIFO, holding at the maximum value.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign {rec_write, rec_addr, rec_data} = mem[rd_ptr];

endmodule

// File: tb/tb_apb_txn_monitor.sv
// Bench for apb_txn_monitor: directed APB transfers, expected records queued at
// issue time and compared by a monitor whenever the DUT hands over a record.

module tb_apb_txn_monitor;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 8;

   logic              pclk = 1'b0;
   logic              preset_n;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              rec_valid;
   logic              rec_ready;
   logic              rec_write;
   logic [ADDR_W-1:0] rec_addr;
   logic [DATA_W-1:0] rec_data;
   logic [3:0]        fill_level;
   logic              proto_err;
   logic [1:0]        err_code;
   logic              err_clr;
   logic [CNT_W-1:0]  ovf_cnt;

   typedef struct packed {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } rec_t;

   rec_t expQ[$];
   rec_t monExp;
   int   checks = 0;
   int   errors = 0;

   apb_txn_monitor #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_write (rec_write),
      .rec_addr  (rec_addr),
      .rec_data  (rec_data),
      .fill_level(fill_level),
      .proto_err (proto_err),
      .err_code  (err_code),
      .err_clr   (err_clr),
      .ovf_cnt   (ovf_cnt)
   );

   // Free-running APB clock, 10 time units per cycle.
   always #5 pclk = ~pclk;

   // Hard stop so a stuck run still reports itself.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual %0h required %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic busIdle();
      psel    = 1'b0;
      penable = 1'b0;
      pready  = 1'b0;
   endtask

   // One complete APB transfer; optionally queues its record and pops the head on the completion edge.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int waits, input bit store, input bit popAtDone);
      rec_t       r;
      logic [3:0] fillStart;
      logic [1:0] codeStart;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = w;
      paddr   = a;
      pwdata  = wd;
      pready  = 1'b0;
      prdata  = 32'hBAD0_BAD0;
      tick();
      fillStart = fill_level;
      codeStart = err_code;
      penable   = 1'b1;
      for (int i = 0; i < waits; i++) begin
         tick();
         checkOutput("wait_fill", fill_level, fillStart);
         checkOutput("wait_code", err_code, codeStart);
      end
      pready = 1'b1;
      prdata = rd;
      r.w = w;
      r.a = a;
      r.d = w ? wd : rd;
      if (store) expQ.push_back(r);
      if (popAtDone) rec_ready = 1'b1;
      tick();
      busIdle();
      if (popAtDone) rec_ready = 1'b0;
   endtask

   // Drain the FIFO with a cycle budget; running out of budget shows up as a failed check.
   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      rec_ready = 1'b1;
      while (fill_level != 0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("drain_fill", fill_level, 0);
      checkOutput("drain_valid", rec_valid, 0);
      rec_ready = 1'b0;
   endtask

   // Scoreboard monitor: every record handed over is compared with the oldest expected one.
   always @(negedge pclk) begin
      if (preset_n && rec_valid && rec_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected actual addr %0h required no record", rec_addr);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("sb_write", rec_write, monExp.w);
            checkOutput("sb_addr", rec_addr, monExp.a);
            checkOutput("sb_data", rec_data, monExp.d);
         end
      end
   end

   // Directed test sequence.
   initial begin
      preset_n  = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      pwrite    = 1'b0;
      paddr     = '0;
      pwdata    = '0;
      prdata    = '0;
      pready    = 1'b0;
      rec_ready = 1'b0;
      err_clr   = 1'b0;
      #2;
      checkOutput("rst_valid", rec_valid, 0);
      checkOutput("rst_fill", fill_level, 0);
      checkOutput("rst_err", proto_err, 0);
      checkOutput("rst_code", err_code, 0);
      checkOutput("rst_ovf", ovf_cnt, 0);
      checkOutput("rst_addr", rec_addr, 0);
      checkOutput("rst_data", rec_data, 0);
      tick();
      tick();
      preset_n = 1'b1;
      tick();

      $display("[TB] zero-wait write");
      applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b1, 1'b0);
      checkOutput("wr_valid", rec_valid, 1);
      checkOutput("wr_write", rec_write, 1);
      checkOutput("wr_addr", rec_addr, 32'h10);
      checkOutput("wr_data", rec_data, 32'hDEADBEEF);
      checkOutput("wr_fill", fill_level, 1);

      $display("[TB] read with three wait states");
      applyStimulus(1'b0, 32'h20, 32'h0, 32'h12345678, 3, 1'b1, 1'b0);
      checkOutput("rd_fill", fill_level, 2);
      checkOutput("rd_err", proto_err, 0);
      waitDrain(20);

      $display("[TB] overflow");
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0, 0, (i < 8), 1'b0);
      checkOutput("ovf_fill", fill_level, 8);
      checkOutput("ovf_cnt", ovf_cnt, 2);
      checkOutput("ovf_head", rec_addr, 32'h100);
      checkOutput("ovf_headdata", rec_data, 32'hA000_0000);
      applyStimulus(1'b1, 32'h200, 32'hC0FFEE00, 32'h0, 0, 1'b1, 1'b1);
      checkOutput("fullpp_fill", fill_level, 8);
      checkOutput("fullpp_ovf", ovf_cnt, 2);
      checkOutput("fullpp_head", rec_addr, 32'h104);
      waitDrain(30);

      $display("[TB] protocol violations");
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
      tick();
      checkOutput("e1_flag", proto_err, 1);
      checkOutput("e1_code", err_code, 1);
      busIdle();
      tick();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h1;
      tick();
      penable = 1'b1; pready = 1'b0;
      tick();
      paddr = 32'h44; pready = 1'b1;
      tick();
      busIdle();
      checkOutput("e3_flag", proto_err, 1);
      checkOutput("e3_code", err_code, 1);
      checkOutput("e3_fill", fill_level, 0);
      checkOutput("e3_valid", rec_valid, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("clr_flag", proto_err, 0);
      checkOutput("clr_code", err_code, 0);
      psel = 1'b1; penable = 1'b1;
      tick();
      checkOutput("e1b_code", err_code, 1);
      penable = 1'b0; paddr = 32'h48;
      tick();
      busIdle();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("e2_flag", proto_err, 1);
      checkOutput("e2_code", err_code, 2);

      $display("[TB] reset during access");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 32'h300 + 32'(i * 4), 32'h7700 + 32'(i), 32'h0, 0, 1'b1, 1'b0);
      checkOutput("pre_rst_fill", fill_level, 3);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h60; pwdata = 32'h66;
      tick();
      penable = 1'b1; pready = 1'b0;
      tick();
      #2;
      preset_n = 1'b0;
      #1;
      checkOutput("mr_valid", rec_valid, 0);
      checkOutput("mr_fill", fill_level, 0);
      checkOutput("mr_err", proto_err, 0);
      checkOutput("mr_code", err_code, 0);
      checkOutput("mr_ovf", ovf_cnt, 0);
      checkOutput("mr_addr", rec_addr, 0);
      checkOutput("mr_write", rec_write, 0);
      expQ.delete();
      busIdle();
      tick();
      tick();
      preset_n = 1'b1;
      tick();
      applyStimulus(1'b1, 32'h80, 32'h55AA55AA, 32'h0, 0, 1'b1, 1'b0);
      checkOutput("post_fill", fill_level, 1);
      checkOutput("post_addr", rec_addr, 32'h80);
      checkOutput("post_data", rec_data, 32'h55AA55AA);
      checkOutput("post_err", proto_err, 0);
      waitDrain(20);
      checkOutput("sb_left", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
